// File: rtl/lr_pkt_writer_if.sv
// ---------------------------------------------------------------------------
// lr_pkt_writer_if
//   Groups the RX byte-stream handshake and the local-RAM write port of
//   lr_pkt_writer.
//
//   Stream : in_data[7:0], in_valid, in_sop, in_eop -> writer ; in_ready <-
//   RAM    : ram_addr[11:0], ram_data[31:0], ram_we[3:0], ram_en   <- writer
//
//   Modports
//     master : the RX source / RAM observer side
//     slave  : the writer itself
// ---------------------------------------------------------------------------
interface lr_pkt_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;

    logic [11:0] ram_addr;
    logic [31:0] ram_data;
    logic [3:0]  ram_we;
    logic        ram_en;

    modport master (
        output in_data, in_valid, in_sop, in_eop,
        input  in_ready,
        input  ram_addr, ram_data, ram_we, ram_en
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop,
        output in_ready,
        output ram_addr, ram_data, ram_we, ram_en
    );
endinterface

// File: rtl/lr_pkt_writer.sv
// ---------------------------------------------------------------------------
// lr_pkt_writer
//   Writes an Ethernet RX byte stream into a 32-bit local RAM using per-lane
//   byte enables (little-endian lane order), then writes a length/status
//   header word at BASE_WORD. The buffer is held until the owning core pulses
//   i_release.
//
//   Parameters
//     BASE_WORD : word address of the header; payload starts at BASE_WORD+1
//     MAX_BYTES : payload byte limit (BASE_WORD+1+ceil(MAX_BYTES/4) <= 4096)
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        stream in / RAM write out (lr_pkt_writer_if.slave)
//     pkt_ready  packet plus header stored, buffer owned by the core
//     pkt_len    stored byte count of the last packet
//     pkt_trunc  last packet exceeded MAX_BYTES
//     i_release  one-cycle buffer release pulse from the core
//     drop_cnt   saturating count of discarded / aborted packets
// ---------------------------------------------------------------------------
module lr_pkt_writer #(
    parameter logic [11:0] BASE_WORD = 12'h000,
    parameter int unsigned MAX_BYTES = 1518
) (
    input  logic                 clk,
    input  logic                 reset,
    lr_pkt_writer_if.slave       bus,
    output logic                 pkt_ready,
    output logic [15:0]          pkt_len,
    output logic                 pkt_trunc,
    input  logic                 i_release,
    output logic [7:0]           drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_HDR,
        S_WAIT_REL
    } state_t;

    localparam logic [15:0] MAX_CNT  = 16'(MAX_BYTES);
    localparam logic [11:0] PAY_BASE = BASE_WORD + 12'd1;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_trunc;
    logic        r_in_ready;
    logic [11:0] r_ram_addr;
    logic [31:0] r_ram_data;
    logic [3:0]  r_ram_we;
    logic        r_ram_en;
    logic        r_pkt_ready;
    logic [15:0] r_pkt_len;
    logic        r_pkt_trunc;
    logic [7:0]  r_drop_cnt;

    logic        w_accept;
    logic        w_restart;
    logic        w_cont;
    logic        w_take;
    logic        w_drop;
    logic [15:0] w_idx;
    logic        w_fits;
    logic        w_write;
    logic [15:0] w_cnt_nxt;
    logic        w_trunc_nxt;
    logic [11:0] w_wr_addr;
    logic [3:0]  w_wr_we;

    // in_ready is only ever high in IDLE/RECV, so an accepted beat implies
    // one of those two states.
    assign w_accept  = bus.in_valid & r_in_ready;
    // sop always starts byte 0, whether from IDLE or aborting a packet in RECV
    assign w_restart = w_accept & bus.in_sop;
    assign w_cont    = w_accept & ~bus.in_sop & (r_state == S_RECV);
    assign w_take    = w_restart | w_cont;
    assign w_drop    = (w_accept & ~bus.in_sop & (r_state == S_IDLE))
                     | (w_restart & (r_state == S_RECV));

    assign w_idx       = w_restart ? '0 : r_cnt;
    assign w_fits      = (w_idx < MAX_CNT);
    assign w_write     = w_take & w_fits;
    // Counter stops at MAX_BYTES; later bytes only set the trunc flag.
    assign w_cnt_nxt   = w_write ? (w_idx + 16'd1) : w_idx;
    assign w_trunc_nxt = (w_take & ~w_fits) | (~w_restart & r_trunc);
    assign w_wr_addr   = PAY_BASE + 12'(w_idx >> 2);
    assign w_wr_we     = 4'b0001 << w_idx[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_we    <= '0;
            r_ram_en    <= 1'b0;
            r_pkt_ready <= 1'b0;
            r_pkt_len   <= '0;
            r_pkt_trunc <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            // RAM strobes are single-cycle pulses
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_we   <= '0;
            r_ram_en   <= 1'b0;

            case (r_state)
                S_IDLE, S_RECV: begin
                    if (w_drop && (r_drop_cnt != 8'hFF)) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                    if (w_take) begin
                        r_cnt   <= w_cnt_nxt;
                        r_trunc <= w_trunc_nxt;
                        if (bus.in_eop) begin
                            r_state     <= S_HDR;
                            r_in_ready  <= 1'b0;
                            r_pkt_len   <= w_cnt_nxt;
                            r_pkt_trunc <= w_trunc_nxt;
                        end else begin
                            r_state    <= S_RECV;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                    if (w_write) begin
                        r_ram_addr <= w_wr_addr;
                        r_ram_data <= {4{bus.in_data}};
                        r_ram_we   <= w_wr_we;
                        r_ram_en   <= 1'b1;
                    end
                end

                S_HDR: begin
                    r_ram_addr  <= BASE_WORD;
                    r_ram_data  <= {r_trunc, 15'b0, r_cnt};
                    r_ram_we    <= 4'hF;
                    r_ram_en    <= 1'b1;
                    r_pkt_ready <= 1'b1;
                    r_in_ready  <= 1'b0;
                    r_state     <= S_WAIT_REL;
                end

                S_WAIT_REL: begin
                    if (i_release) begin
                        r_state     <= S_IDLE;
                        r_pkt_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_trunc     <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_data = r_ram_data;
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_en   = r_ram_en;
    assign pkt_ready    = r_pkt_ready;
    assign pkt_len      = r_pkt_len;
    assign pkt_trunc    = r_pkt_trunc;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_lr_pkt_writer.sv
// ---------------------------------------------------------------------------
// tb_lr_pkt_writer
//   Two writers share one stimulus stream: dut_a (BASE_WORD 0, MAX_BYTES
//   1518) and dut_b (BASE_WORD 0x100, MAX_BYTES 8). A shadow RAM per DUT
//   collects every write; packet results are checked against the byte list
//   that was sent.
// ---------------------------------------------------------------------------
module tb_lr_pkt_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic rel;

    logic        prdy_a, prdy_b, trunc_a, trunc_b;
    logic [15:0] len_a, len_b;
    logic [7:0]  drop_a, drop_b;

    lr_pkt_writer_if ifa ();
    lr_pkt_writer_if ifb ();

    lr_pkt_writer #(.BASE_WORD(12'h000), .MAX_BYTES(1518)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa),
        .pkt_ready(prdy_a), .pkt_len(len_a), .pkt_trunc(trunc_a),
        .i_release(rel), .drop_cnt(drop_a)
    );

    lr_pkt_writer #(.BASE_WORD(12'h100), .MAX_BYTES(8)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb),
        .pkt_ready(prdy_b), .pkt_len(len_b), .pkt_trunc(trunc_b),
        .i_release(rel), .drop_cnt(drop_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int bases[2] = '{0, 256};
    int maxs[2]  = '{1518, 8};
    int exp_drop[2];

    // sampled DUT outputs
    logic        o_rdy[2], o_en[2], o_prdy[2], o_trunc[2];
    logic [3:0]  o_we[2];
    logic [11:0] o_addr[2];
    logic [31:0] o_data[2];
    logic [15:0] o_len[2];
    logic [7:0]  o_drop[2];

    // shadow RAM
    logic [7:0]  sh_dat[2][4096][4];
    bit          sh_v[2][4096][4];
    int          wr_cnt[2];
    int          last_addr[2];
    int          last_we[2];

    logic [7:0]  pkt_q[$];

    typedef struct {
        logic [7:0]  d;
        logic        v, s, e, r;
        logic        rdy, en;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        prdy;
        int          len;
        logic [7:0]  drops;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] d, logic v, logic s, logic e, logic r,
                                logic rdy, logic en, logic [3:0] we, logic [11:0] a,
                                logic [31:0] dt, logic pr, int len, logic [7:0] dr);
        vec_t t;
        t.d = d; t.v = v; t.s = s; t.e = e; t.r = r;
        t.rdy = rdy; t.en = en; t.we = we; t.addr = a; t.data = dt;
        t.prdy = pr; t.len = len; t.drops = dr;
        return t;
    endfunction

    function automatic int sat(int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic sample();
        o_rdy[0] = ifa.in_ready;  o_rdy[1] = ifb.in_ready;
        o_en[0]  = ifa.ram_en;    o_en[1]  = ifb.ram_en;
        o_we[0]  = ifa.ram_we;    o_we[1]  = ifb.ram_we;
        o_addr[0] = ifa.ram_addr; o_addr[1] = ifb.ram_addr;
        o_data[0] = ifa.ram_data; o_data[1] = ifb.ram_data;
        o_prdy[0] = prdy_a;  o_prdy[1] = prdy_b;
        o_len[0]  = len_a;   o_len[1]  = len_b;
        o_trunc[0] = trunc_a; o_trunc[1] = trunc_b;
        o_drop[0] = drop_a;  o_drop[1] = drop_b;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        for (int x = 0; x < 2; x++) begin
            if (o_en[x]) begin
                wr_cnt[x]++;
                for (int l = 0; l < 4; l++) begin
                    if (o_we[x][l]) begin
                        sh_dat[x][o_addr[x]][l] = o_data[x][8*l +: 8];
                        sh_v[x][o_addr[x]][l]   = 1'b1;
                    end
                end
                if (o_we[x] != 4'hF) begin
                    last_addr[x] = int'(o_addr[x]);
                    last_we[x]   = int'(o_we[x]);
                end
            end
        end
    endtask

    task automatic clear_shadow();
        for (int x = 0; x < 2; x++)
            for (int w = 0; w < 4096; w++)
                for (int l = 0; l < 4; l++)
                    sh_v[x][w][l] = 1'b0;
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic e, input logic r);
        ifa.in_data = d; ifa.in_valid = v; ifa.in_sop = s; ifa.in_eop = e;
        ifb.in_data = d; ifb.in_valid = v; ifb.in_sop = s; ifb.in_eop = e;
        rel = r;
    endtask

    // One beat; the writer is expected to be ready (IDLE or RECV).
    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        for (int x = 0; x < 2; x++) chk("beat_ready", x, o_rdy[x], 1);
        drive(d, 1'b1, s, e, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends pkt_q as one packet, checks the stored result, then releases.
    task automatic do_packet();
        int n;
        clear_shadow();
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_beat(pkt_q[i], i == 0, i == n - 1);
        end
        tick();
        for (int x = 0; x < 2; x++) begin
            int len, bad, cntv, b;
            logic tr;
            logic [31:0] hw;
            b   = bases[x];
            len = (n < maxs[x]) ? n : maxs[x];
            tr  = (n > maxs[x]);
            chk("hdr_strobe", x, (o_en[x] && o_we[x] == 4'hF && int'(o_addr[x]) == b), 1);
            chk("pkt_ready", x, o_prdy[x], 1);
            chk("pkt_len", x, o_len[x], len);
            chk("pkt_trunc", x, o_trunc[x], tr);
            chk("drop_cnt", x, o_drop[x], exp_drop[x]);
            hw = {sh_dat[x][b][3], sh_dat[x][b][2], sh_dat[x][b][1], sh_dat[x][b][0]};
            chk("hdr_word", x, hw, {tr, 15'b0, 16'(len)});
            bad = 0;
            for (int i = 0; i < len; i++) begin
                int w = b + 1 + i / 4;
                if (!sh_v[x][w][i % 4] || sh_dat[x][w][i % 4] !== pkt_q[i]) bad++;
            end
            chk("payload_bad", x, bad, 0);
            cntv = 0;
            for (int w = 0; w < 4096; w++)
                for (int l = 0; l < 4; l++)
                    if (sh_v[x][w][l]) cntv++;
            chk("bytes_written", x, cntv, len + 4);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 2; x++) begin
            chk("rel_prdy", x, o_prdy[x], 0);
            chk("rel_ready", x, o_rdy[x], 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w0[2];

        // rows: d v s e r | rdy en we addr data prdy len drops
        tbl.push_back(mk(8'h00,0,0,0,0, 0,0,4'h0,12'h000,32'h0,        0, 0,8'd0));
        tbl.push_back(mk(8'h11,1,1,0,0, 1,0,4'h0,12'h000,32'h0,        0, 0,8'd0));
        tbl.push_back(mk(8'h22,1,0,0,0, 1,1,4'h1,12'h001,32'h11111111, 0, 0,8'd0));
        tbl.push_back(mk(8'h33,1,0,0,0, 1,1,4'h2,12'h001,32'h22222222, 0, 0,8'd0));
        tbl.push_back(mk(8'h44,1,0,0,0, 1,1,4'h4,12'h001,32'h33333333, 0, 0,8'd0));
        tbl.push_back(mk(8'h55,1,0,1,0, 1,1,4'h8,12'h001,32'h44444444, 0, 0,8'd0));
        tbl.push_back(mk(8'h00,0,0,0,0, 0,1,4'h1,12'h002,32'h55555555, 0,-1,8'd0));
        tbl.push_back(mk(8'h99,1,1,1,0, 0,1,4'hF,12'h000,32'h00000005, 1, 5,8'd0));
        tbl.push_back(mk(8'h99,1,1,1,1, 0,0,4'h0,12'h000,32'h0,        1, 5,8'd0));
        tbl.push_back(mk(8'h99,1,1,1,0, 1,0,4'h0,12'h000,32'h0,        0, 5,8'd0));
        tbl.push_back(mk(8'h00,0,0,0,0, 0,1,4'h1,12'h001,32'h99999999, 0,-1,8'd0));
        tbl.push_back(mk(8'h00,0,0,0,1, 0,1,4'hF,12'h000,32'h00000001, 1, 1,8'd0));
        tbl.push_back(mk(8'h77,1,0,0,0, 1,0,4'h0,12'h000,32'h0,        0, 1,8'd0));
        tbl.push_back(mk(8'hA0,1,1,0,0, 1,0,4'h0,12'h000,32'h0,        0, 1,8'd1));
        tbl.push_back(mk(8'hA1,1,0,0,0, 1,1,4'h1,12'h001,32'hA0A0A0A0, 0, 1,8'd1));
        tbl.push_back(mk(8'hA2,1,0,0,0, 1,1,4'h2,12'h001,32'hA1A1A1A1, 0, 1,8'd1));
        tbl.push_back(mk(8'hB0,1,1,0,0, 1,1,4'h4,12'h001,32'hA2A2A2A2, 0, 1,8'd1));
        tbl.push_back(mk(8'hB1,1,0,1,0, 1,1,4'h1,12'h001,32'hB0B0B0B0, 0, 1,8'd2));
        tbl.push_back(mk(8'h00,0,0,0,0, 0,1,4'h2,12'h001,32'hB1B1B1B1, 0,-1,8'd2));
        tbl.push_back(mk(8'h00,0,0,0,1, 0,1,4'hF,12'h000,32'h00000002, 1, 2,8'd2));
        tbl.push_back(mk(8'hAA,1,1,1,0, 1,0,4'h0,12'h000,32'h0,        0, 2,8'd2));
        tbl.push_back(mk(8'h00,0,0,0,0, 0,1,4'h1,12'h001,32'hAAAAAAAA, 0,-1,8'd2));
        tbl.push_back(mk(8'h00,0,0,0,1, 0,1,4'hF,12'h000,32'h00000001, 1, 1,8'd2));
        tbl.push_back(mk(8'h00,0,0,0,0, 1,0,4'h0,12'h000,32'h0,        0, 1,8'd2));

        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        wr_cnt = '{0, 0};
        clear_shadow();
        repeat (3) tick();
        for (int x = 0; x < 2; x++) begin
            chk("rst_ready", x, o_rdy[x], 0);
            chk("rst_en", x, o_en[x], 0);
            chk("rst_we", x, o_we[x], 0);
            chk("rst_addr", x, o_addr[x], 0);
            chk("rst_data", x, o_data[x], 0);
            chk("rst_prdy", x, o_prdy[x], 0);
            chk("rst_len", x, o_len[x], 0);
            chk("rst_trunc", x, o_trunc[x], 0);
            chk("rst_drop", x, o_drop[x], 0);
        end
        reset = 1'b1;

        // cycle-exact vectors against dut_a
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            chk("tbl_ready", i, o_rdy[0], t.rdy);
            chk("tbl_en", i, o_en[0], t.en);
            chk("tbl_we", i, o_we[0], t.we);
            if (t.en) begin
                chk("tbl_addr", i, o_addr[0], t.addr);
                chk("tbl_data", i, o_data[0], t.data);
            end
            chk("tbl_prdy", i, o_prdy[0], t.prdy);
            if (t.len >= 0) chk("tbl_len", i, o_len[0], t.len);
            if (t.prdy) chk("tbl_trunc", i, o_trunc[0], 0);
            chk("tbl_drop", i, o_drop[0], t.drops);
            drive(t.d, t.v, t.s, t.e, t.r);
            tick();
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_drop = '{2, 2};

        // 10-byte packet: dut_b truncates at 8 bytes
        pkt_q.delete();
        for (int i = 0; i < 10; i++) pkt_q.push_back(8'(8'h60 + i));
        w0 = wr_cnt;
        do_packet();
        chk("trunc_wr_cnt", 0, wr_cnt[0] - w0[0], 11);
        chk("trunc_wr_cnt", 1, wr_cnt[1] - w0[1], 9);
        chk("trunc_last_addr", 1, last_addr[1], 12'h102);
        chk("trunc_last_we", 1, last_we[1], 4'h8);

        // randomized packets, garbage beats and aborts
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                repeat ($urandom_range(1, 3)) begin
                    send_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
                    for (int x = 0; x < 2; x++) exp_drop[x] = sat(exp_drop[x]);
                end
            end else begin
                if (r < 4) begin
                    int k;
                    k = $urandom_range(1, 3);
                    for (int i = 0; i < k; i++) send_beat(8'($urandom), i == 0, 1'b0);
                    for (int x = 0; x < 2; x++) exp_drop[x] = sat(exp_drop[x]);
                end
                pkt_q.delete();
                repeat ($urandom_range(1, 12)) pkt_q.push_back(8'($urandom));
                do_packet();
            end
        end

        // drop counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            for (int x = 0; x < 2; x++) exp_drop[x] = sat(exp_drop[x]);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int x = 0; x < 2; x++) chk("drop_sat", x, o_drop[x], exp_drop[x]);

        // reset in the middle of a packet
        for (int i = 0; i < 6; i++) send_beat(8'(8'h30 + i), i == 0, 1'b0);
        #2 reset = 1'b0;
        #1 sample();
        for (int x = 0; x < 2; x++) begin
            chk("mid_rst_ready", x, o_rdy[x], 0);
            chk("mid_rst_en", x, o_en[x], 0);
            chk("mid_rst_we", x, o_we[x], 0);
            chk("mid_rst_addr", x, o_addr[x], 0);
            chk("mid_rst_data", x, o_data[x], 0);
            chk("mid_rst_prdy", x, o_prdy[x], 0);
            chk("mid_rst_len", x, o_len[x], 0);
            chk("mid_rst_drop", x, o_drop[x], 0);
        end
        repeat (2) tick();
        reset = 1'b1;
        w0 = wr_cnt;
        tick();
        for (int x = 0; x < 2; x++) chk("post_rst_ready", x, o_rdy[x], 1);
        repeat (6) tick();
        for (int x = 0; x < 2; x++) begin
            chk("post_rst_no_write", x, wr_cnt[x] - w0[x], 0);
            chk("post_rst_prdy", x, o_prdy[x], 0);
            chk("post_rst_ready2", x, o_rdy[x], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lr_pkt_writer.md
Name: lr_pkt_writer

Overview:
- Upstream write stage for the 16 KB, 32-bit local RAM of each core.
- Consumes the byte stream coming out of the Ethernet RX path.
- Writes each byte straight into the RAM through its per-byte-lane write enables, then writes a length/status header word.
- Holds the buffer until the owning core releases it (single-buffer handshake).

Parameters:
- BASE_WORD, 12'h000: word address of the header word. Payload starts at BASE_WORD+1.
- MAX_BYTES, 1518: payload byte limit. Bytes beyond it are not written. Legal only if BASE_WORD + 1 + ceil(MAX_BYTES/4) <= 4096.

Ports:
- clk  input  1  clock, all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_data  input  8  RX byte
- in_valid  input  1  in_data is valid this cycle
- in_sop  input  1  first byte of packet (qualified by in_valid)
- in_eop  input  1  last byte of packet (qualified by in_valid)
- in_ready  output  1  beat accepted when in_valid & in_ready
- ram_addr  output  12  word address, drives RAM addr[13:2]
- ram_data  output  32  write data
- ram_we  output  4  byte-lane write enables; we[k] covers data[8k+7:8k]
- ram_en  output  1  RAM clock enable, high only on write cycles
- pkt_ready  output  1  a complete packet plus header is in RAM
- pkt_len  output  16  stored byte count of the last packet
- pkt_trunc  output  1  last packet exceeded MAX_BYTES
- release  input  1  one-cycle pulse from the core freeing the buffer
- drop_cnt  output  8  saturating count of discarded or aborted packets

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready=0 while reset is held; all ram_* = 0; pkt_ready=0, pkt_len=0, pkt_trunc=0, drop_cnt=0; byte counter=0. A packet in flight is lost and its header is not written.
- Outputs: all registered. ram_* for an accepted beat appear the cycle after acceptance and last exactly one cycle.
- States:
  - IDLE: in_ready=1.
    - Beat with sop: byte 0 is written, counter=1, go to RECV. If eop is also set, go to HDR instead.
    - Beat without sop: consumed and discarded, drop_cnt+1.
  - RECV: in_ready=1.
    - Each beat at byte index n (n < MAX_BYTES): ram_addr = BASE_WORD+1+n[15:2]; ram_we = one-hot lane n[1:0] (1<<n[1:0]); ram_data = {4{in_data}}; ram_en=1.
    - n >= MAX_BYTES: no write (ram_en=0), trunc flag set, counter holds at MAX_BYTES.
    - Beat with eop: go to HDR after the final byte is processed.
    - Beat with sop in RECV: current packet aborted, drop_cnt+1, no header written. The beat restarts as byte 0 of a new packet; trunc flag cleared.
  - HDR (one cycle): in_ready=0.
    - Write ram_addr = BASE_WORD, ram_we = 4'hF, ram_data = {trunc, 15'b0, count[15:0]}.
    - This header write occurs the cycle after the last byte write.
    - Next state WAIT_REL.
  - WAIT_REL: in_ready=0; pkt_ready=1; pkt_len and pkt_trunc hold the header values (updated on HDR entry).
    - release=1 → IDLE: pkt_ready=0 next cycle, counter and trunc cleared.
  - release outside WAIT_REL is ignored.
- Counter: 16-bit, saturates at MAX_BYTES.
- Byte lane order: little-endian (byte 4k+j → lane j).
- drop_cnt: saturates at 8'hFF.
- in_valid with in_ready=0: not accepted. Upstream must hold the beat until in_ready=1.

Test Plan:
- Reset, then 5-byte packet 11,22,33,44,55 (sop on 11, eop on 55): writes word1 lanes 0-3, then word2 lane0=55. Next cycle header word0=32'h0000_0005, we=F. pkt_ready=1, pkt_len=5, in_ready=0.
- Single-byte packet with sop&eop, value AA: word1 we=0001, data AAAAAAAA. Header 32'h0000_0001 the following cycle.
- MAX_BYTES=8, 10-byte packet: only 8 byte writes, last at word2 lane3. Header 32'h8000_0008, pkt_trunc=1.
- In WAIT_REL, drive in_valid: never accepted. Pulse release: pkt_ready=0 and in_ready=1 next cycle. Next packet starts at word1 lane0.
- Non-sop beat in IDLE → drop_cnt=1, no RAM write. Sop at byte 3 of a packet → drop_cnt=2, new packet byte 0 written to word1 lane0.
- Assert reset mid-packet after 6 bytes: outputs zero immediately. After deassert, in_ready=1 and no header is ever written for the lost packet.
